// File: rtl/rom_access_arbiter_pkg.sv
// Shared definitions for the program-ROM access arbiter: sizes, FSM states
// and the owner tag that routes read responses back to the issuing port.
package rom_access_arbiter_pkg;

  localparam int XLEN      = 32;
  localparam int ROM_DEPTH = 2048;
  localparam int ADDR_W    = $clog2(ROM_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PGM   = 2'd2
  } state_e;

  // Owner value doubles as the requester index inside the round-robin arbiter.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DR = 1'b1
  } owner_e;

endpackage

// File: rtl/rom_access_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. The pointer names the port that wins a
// tie; after any grant it moves to the port that was not granted.
module rr_arb2
  import rom_access_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = (ptr_q == OWN_DR) ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // Granting IF hands priority to DR and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && (gnt_o != 2'b00)) begin
      ptr_d = gnt_o[OWN_IF];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= OWN_IF;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rom_access_arbiter.sv
// Single-port program-ROM arbiter: round-robin IF/DR reads with tagged
// one-cycle responses, plus a loader write mode that holds the core.
module rom_access_arbiter
  import rom_access_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic              if_err,
  input  logic              dr_req,
  input  logic [XLEN-1:0]   dr_addr,
  output logic              dr_gnt,
  output logic              dr_rvalid,
  output logic              dr_err,
  output logic [XLEN-1:0]   rdata,
  input  logic              pg_start,
  input  logic              pg_done,
  input  logic              pg_req,
  input  logic [ADDR_W-1:0] pg_addr,
  input  logic [XLEN-1:0]   pg_wdata,
  output logic              pg_gnt,
  output logic              core_hold,
  output logic              rom_en,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [XLEN-1:0]   rom_wdata,
  input  logic [XLEN-1:0]   rom_rdata,
  output logic [1:0]        dbg_state
);

  state_e      state_q;
  logic        core_hold_q;
  logic        rvalid_q;
  owner_e      owner_q;
  logic        err_q;

  logic [1:0]      gnt;
  logic            arb_en;
  logic            arb_ptr;
  logic            rd_go;
  logic            rd_oor;
  logic            pg_wr;
  logic [XLEN-1:0] sel_addr;
  logic            unused_addr_bits;

  // pg_start wins over any read in the cycle it arrives.
  assign arb_en = (state_q == ST_RUN) && !pg_start && !rst;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .req_i ({dr_req, if_req}),
    .en_i  (arb_en),
    .adv_i (rd_go),
    .gnt_o (gnt),
    .ptr_o (arb_ptr)
  );

  assign rd_go    = |gnt;
  assign sel_addr = gnt[OWN_DR] ? dr_addr : if_addr;
  assign rd_oor   = |sel_addr[XLEN-1:ADDR_W+2];
  assign pg_wr    = (state_q == ST_PGM) && pg_req && !rst;

  assign unused_addr_bits = &{sel_addr[1:0], arb_ptr};

  always_comb begin
    rom_en    = 1'b0;
    rom_we    = 1'b0;
    rom_addr  = '0;
    rom_wdata = '0;
    if (pg_wr) begin
      rom_en    = 1'b1;
      rom_we    = 1'b1;
      rom_addr  = pg_addr;
      rom_wdata = pg_wdata;
    end else if (rd_go && !rd_oor) begin
      rom_en   = 1'b1;
      rom_addr = sel_addr[ADDR_W+1:2];
    end
  end

  assign if_gnt = gnt[OWN_IF];
  assign dr_gnt = gnt[OWN_DR];
  assign pg_gnt = pg_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      core_hold_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pg_start) begin
            state_q     <= ST_DRAIN;
            core_hold_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          state_q     <= ST_PGM;
          core_hold_q <= 1'b1;
        end
        ST_PGM: begin
          if (pg_done) begin
            state_q     <= ST_RUN;
            core_hold_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          core_hold_q <= 1'b0;
        end
      endcase
    end
  end

  // Response tag: one read in flight at most, returned the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      owner_q  <= OWN_IF;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_go;
      owner_q  <= gnt[OWN_DR] ? OWN_DR : OWN_IF;
      err_q    <= rd_go && rd_oor;
    end
  end

  assign if_rvalid = rvalid_q && (owner_q == OWN_IF);
  assign dr_rvalid = rvalid_q && (owner_q == OWN_DR);
  assign if_err    = if_rvalid && err_q;
  assign dr_err    = dr_rvalid && err_q;
  assign rdata     = (rvalid_q && !err_q) ? rom_rdata : '0;
  assign core_hold = core_hold_q;
  assign dbg_state = state_q;

endmodule
